stream_downsize128to32: RTL and testbench

Downstream neighbour of the 128-bit loopback kernel: takes its 128-bit output stream (valid/rdy), buffers up to DEPTH words in a small FIFO, and serializes each word onto a 32-bit output stream as four beats. It decouples the kernel from a narrower, possibly stalling consumer such as a 32-bit host stream or a debug/trace port. Lane order matches the kernel's packing: beat 0 = bits [31:0] (last input), beat 1 = [63:32] (sum), beat 2 = [95:64] (average), beat 3 = [127:96] (count).

---
 rtl/stream_downsize128to32.sv | 105 ++++++++++
 tb/tb_stream_downsize128to32.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsize128to32.sv
// 128-bit to 32-bit stream width converter: DEPTH-word show-ahead FIFO feeding a
// 4-beat serializer, with occupancy level and emitted-word counter.
module stream_downsize128to32 #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSW_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s1i_valid,
  output logic                     s1i_rdy,
  input  logic [127:0]             s1i_data,
  output logic                     s1o_valid,
  input  logic                     s1o_rdy,
  output logic [31:0]              s1o_data,
  output logic                     s1o_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              words_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    beat_q, beat_d;
  logic [31:0]   words_q, words_d;
  logic          live_q;

  logic          push;
  logic          beat_fire;
  logic          pop;
  logic [1:0]    lane;
  logic [127:0]  head;

  // live_q holds s1i_rdy low for the first edge after reset release.
  assign s1i_rdy   = live_q && (level_q < LVL_FULL);
  assign s1o_valid = (level_q != '0);
  assign s1o_last  = s1o_valid && (beat_q == 2'd3);
  assign level     = level_q;
  assign words_out = words_q;

  assign push      = s1i_valid && s1i_rdy;
  assign beat_fire = s1o_valid && s1o_rdy;
  assign pop       = beat_fire && (beat_q == 2'd3);

  always_comb begin
    lane     = MSW_FIRST ? ~beat_q : beat_q;
    head     = mem_q[rptr_q];
    s1o_data = '0;
    if (s1o_valid) begin
      case (lane)
        2'd0:    s1o_data = head[31:0];
        2'd1:    s1o_data = head[63:32];
        2'd2:    s1o_data = head[95:64];
        default: s1o_data = head[127:96];
      endcase
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    beat_d  = beat_q;
    words_d = words_q;
    if (push)      wptr_d = wptr_q + PTR_ONE;
    if (beat_fire) beat_d = beat_q + 2'd1;
    if (pop) begin
      rptr_d  = rptr_q + PTR_ONE;
      words_d = words_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= s1i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      beat_q  <= '0;
      words_q <= '0;
      live_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      beat_q  <= beat_d;
      words_q <= words_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_downsize128to32.sv
// Self-checking bench for stream_downsize128to32: LSB-first and MSB-first instances
// sharing one input stream, table-driven single words plus multi-cycle sequences.
module tb_stream_downsize128to32;

  logic         clk;
  logic         rst;
  logic         s1i_valid;
  logic         s1i_rdy;
  logic [127:0] s1i_data;
  logic         s1o_valid;
  logic         s1o_rdy;
  logic [31:0]  s1o_data;
  logic         s1o_last;
  logic [2:0]   level;
  logic [31:0]  words_out;

  logic         m_s1i_rdy;
  logic         m_s1o_valid;
  logic [31:0]  m_s1o_data;
  logic         m_s1o_last;
  logic [2:0]   m_level;
  logic [31:0]  m_words_out;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_words = 0;

  stream_downsize128to32 #(.DEPTH(4), .MSW_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s1i_valid(s1i_valid), .s1i_rdy(s1i_rdy), .s1i_data(s1i_data),
    .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(s1o_data), .s1o_last(s1o_last),
    .level(level), .words_out(words_out)
  );

  stream_downsize128to32 #(.DEPTH(4), .MSW_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst),
    .s1i_valid(s1i_valid), .s1i_rdy(m_s1i_rdy), .s1i_data(s1i_data),
    .s1o_valid(m_s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(m_s1o_data), .s1o_last(m_s1o_last),
    .level(m_level), .words_out(m_words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] w;
    logic [31:0]  b0, b1, b2, b3;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word n carries lane values 4n..4n+3, so the beat stream is a plain count.
  function automatic logic [127:0] mk(input int unsigned n);
    logic [127:0] w;
    for (int l = 0; l < 4; l++) w[32*l +: 32] = 32'(n * 4 + l);
    return w;
  endfunction

  task automatic push_word(input logic [127:0] w);
    s1i_valid = 1'b1;
    s1i_data  = w;
    @(posedge clk); #1;
    s1i_valid = 1'b0;
  endtask

  task automatic expect_beats(input logic [127:0] w, input string tag);
    logic [127:0] t;
    t = w;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("%s_valid%0d", tag, j), s1o_valid, 1'b1);
      chk($sformatf("%s_data%0d", tag, j), s1o_data, t[32*j +: 32]);
      chk($sformatf("%s_last%0d", tag, j), s1o_last, (j == 3));
      @(posedge clk); #1;
    end
    exp_words++;
  endtask

  task automatic stream(input int unsigned nwords, input int unsigned base, input bit bp);
    fork
      begin : producer
        for (int n = 0; n < int'(nwords); n++) begin
          bit acc;
          int guard;
          acc = 1'b0;
          guard = 0;
          s1i_valid = 1'b1;
          s1i_data  = mk(base + n);
          while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = s1i_rdy;
            @(posedge clk); #1;
            guard++;
          end
          if (!acc) begin
            checks++; errors++;
            $display("FAIL stream_push_timeout actual=%0d required=accept", n);
            break;
          end
        end
        s1i_valid = 1'b0;
      end
      begin : consumer
        int unsigned e;
        int cyc;
        bit stalled;
        logic [31:0] prev;
        e = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (e < nwords * 4 && cyc < 20000) begin
          s1o_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          @(negedge clk);
          if (s1o_valid) begin
            chk($sformatf("bs_data%0d", e), s1o_data, 32'(base * 4 + e));
            chk($sformatf("bs_last%0d", e), s1o_last, (e % 4 == 3));
            if (stalled) chk($sformatf("bs_hold%0d", e), s1o_data, prev);
          end else begin
            chk($sformatf("bs_idle_data%0d", e), s1o_data, 32'd0);
          end
          stalled = s1o_valid && !s1o_rdy;
          prev = s1o_data;
          if (s1o_valid && s1o_rdy) e++;
          @(posedge clk); #1;
          cyc++;
        end
        chk("bs_beats_done", e, nwords * 4);
        s1o_rdy = 1'b1;
      end
    join
    exp_words += nwords;
  endtask

  initial begin
    vec_t tbl[4];
    logic [31:0] eb[4];
    logic [127:0] a, b, c, d;

    tbl[0] = '{128'h00000004_00000003_00000002_00000001,
               32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};
    tbl[1] = '{128'hDEADBEEF_CAFEF00D_12345678_89ABCDEF,
               32'h89ABCDEF, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
    tbl[2] = '{128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
               32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    tbl[3] = '{128'h80000000_00000001_7FFFFFFF_FFFFFFFE,
               32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};

    rst = 1'b0; s1i_valid = 1'b0; s1i_data = '0; s1o_rdy = 1'b1;

    #12;
    chk("rst_rdy", s1i_rdy, 1'b0);
    chk("rst_valid", s1o_valid, 1'b0);
    chk("rst_last", s1o_last, 1'b0);
    chk("rst_data", s1o_data, 32'd0);
    chk("rst_level", level, 3'd0);
    chk("rst_words", words_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("release_rdy_low", s1i_rdy, 1'b0);
    @(posedge clk); #1;
    chk("release_rdy_high", s1i_rdy, 1'b1);

    // Single words: LSB-first and MSB-first lane order, latency of one cycle.
    for (int k = 0; k < 4; k++) begin
      eb[0] = tbl[k].b0; eb[1] = tbl[k].b1; eb[2] = tbl[k].b2; eb[3] = tbl[k].b3;
      push_word(tbl[k].w);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk($sformatf("v%0d_valid%0d", k, j), s1o_valid, 1'b1);
        chk($sformatf("v%0d_data%0d", k, j), s1o_data, eb[j]);
        chk($sformatf("v%0d_last%0d", k, j), s1o_last, (j == 3));
        chk($sformatf("v%0d_mdata%0d", k, j), m_s1o_data, eb[3-j]);
        chk($sformatf("v%0d_mlast%0d", k, j), m_s1o_last, (j == 3));
        @(posedge clk); #1;
      end
      exp_words++;
      chk($sformatf("v%0d_words", k), words_out, exp_words);
      chk($sformatf("v%0d_mwords", k), m_words_out, exp_words);
      chk($sformatf("v%0d_level", k), level, 3'd0);
      chk($sformatf("v%0d_idle", k), s1o_valid, 1'b0);
    end

    // Fill to full with the consumer stalled, then drain.
    s1o_rdy = 1'b0;
    for (int c2 = 0; c2 < 6; c2++) begin
      s1i_valid = 1'b1;
      s1i_data  = mk(200 + c2);
      @(negedge clk);
      chk($sformatf("fill_rdy%0d", c2), s1i_rdy, (c2 < 4));
      @(posedge clk); #1;
    end
    s1i_valid = 1'b0;
    chk("fill_level", level, 3'd4);
    chk("fill_head", s1o_data, 32'd800);
    s1o_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("full_data%0d", j), s1o_data, 32'(800 + j));
      chk($sformatf("full_rdy%0d", j), s1i_rdy, 1'b0);
      @(posedge clk); #1;
    end
    exp_words++;
    chk("full_rdy_back", s1i_rdy, 1'b1);
    chk("full_level3", level, 3'd3);
    expect_beats(mk(201), "f1");
    expect_beats(mk(202), "f2");
    expect_beats(mk(203), "f3");
    chk("fill_words", words_out, exp_words);
    chk("fill_level0", level, 3'd0);

    // Random backpressure over 100 words.
    stream(100, 1000, 1'b1);
    chk("bp_words", words_out, exp_words);
    chk("bp_level", level, 3'd0);

    // Push on the same edge as a final-beat pop.
    a = mk(300); b = mk(301); c = mk(302);
    s1o_rdy = 1'b0;
    push_word(a);
    push_word(b);
    chk("pp_level2", level, 3'd2);
    s1o_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        s1i_valid = 1'b1;
        s1i_data  = c;
      end
      @(negedge clk);
      chk($sformatf("pp_a%0d", j), s1o_data, a[32*j +: 32]);
      @(posedge clk); #1;
    end
    s1i_valid = 1'b0;
    exp_words++;
    chk("pp_level_hold", level, 3'd2);
    chk("pp_words", words_out, exp_words);
    expect_beats(b, "ppb");
    expect_beats(c, "ppc");
    chk("pp_level0", level, 3'd0);

    // Asynchronous reset in the middle of a word with three queued.
    s1o_rdy = 1'b0;
    push_word(mk(400));
    push_word(mk(401));
    push_word(mk(402));
    s1o_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_beat2", s1o_data, 32'd1602);
    rst = 1'b0;
    #1;
    chk("mr_valid", s1o_valid, 1'b0);
    chk("mr_level", level, 3'd0);
    chk("mr_words", words_out, 32'd0);
    chk("mr_data", s1o_data, 32'd0);
    chk("mr_rdy", s1i_rdy, 1'b0);
    exp_words = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_rdy_back", s1i_rdy, 1'b1);
    d = mk(500);
    push_word(d);
    expect_beats(d, "mrd");
    chk("mr_words1", words_out, exp_words);

    // Pointer wrap: 2*DEPTH+1 words streamed with no backpressure.
    stream(9, 600, 1'b0);
    chk("wrap_words", words_out, exp_words);
    chk("wrap_level", level, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=hang required=finish");
    $fatal(1, "timeout");
  end

endmodule
